ram_access_ctrl: RTL and testbench
==================================

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameter WAIT_STATES, default 2, SHALL set the number of extra RAM cycles per access (legal range 0..15).
REQ-002 Parameter AW, default 9, SHALL set the byte-address width.
REQ-003 Port CLK, input, 1, SHALL be the single clock; all state SHALL change on its rising edge.
REQ-004 Port CLR, input, 1, SHALL be the asynchronous active-low reset.
REQ-005 Port MOV, input, 1: memory-operation-valid from the control unit.
REQ-006 Port RW, input, 1: 1 = read, 0 = write.
REQ-007 Port typeData, input, 2: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 Port addr, input, AW: byte address from MAR.
REQ-009 Port wdata, input, 32: store data from MDR, right-justified.
REQ-010 Port rdata, output, 32: load data to MDR, right-justified and zero-extended.
REQ-011 Port MOC, output, 1: memory-operation-complete to the control unit.
REQ-012 Port fault, output, 1: alignment or type fault for the current operation.
REQ-013 Ports mem_en (out, 1), mem_we (out, 1), mem_addr (out, AW-2, word address), mem_be (out, 4), mem_wdata (out, 32), mem_rdata (in, 32): synchronous RAM side.

Function
REQ-014 The FSM SHALL have the states IDLE, ACCESS, DONE and FAULT.
REQ-015 In IDLE with MOV=1 at an edge, the block SHALL latch addr, RW, typeData and wdata, and then enter ACCESS, or enter FAULT if the operation is illegal.
REQ-016 An operation SHALL be illegal when typeData=11, when a halfword has addr[0]=1, or when a word has addr[1:0]!=00.
REQ-017 In ACCESS, mem_en SHALL be 1 for exactly WAIT_STATES+1 cycles, with mem_we=~RW_latched and mem_addr=addr_latched[AW-1:2].
REQ-018 Byte lane mapping SHALL be little-endian:
  - byte: be = 1 << addr[1:0], and wdata[7:0] is replicated to all lanes.
  - halfword: be = 0011 or 1100, and wdata[15:0] is replicated to both halves.
  - word: be = 1111.
REQ-019 For a read, the block SHALL capture mem_rdata in the final ACCESS cycle, shifted down by the lane offset and zero-extended into rdata; rdata SHALL hold its value until the next read completes.
REQ-020 After the last ACCESS cycle the block SHALL enter DONE; MOC SHALL be 1 throughout DONE.
REQ-021 Latency SHALL be as follows: with MOV sampled at edge n, MOC is first high after edge n+WAIT_STATES+2.
REQ-022 The handshake SHALL be four-phase: DONE and FAULT exit to IDLE only on an edge where MOV=0, and MOC drops after that edge.
REQ-023 In FAULT, MOC and fault SHALL both be 1, mem_en SHALL be 0, and no RAM access SHALL occur.
REQ-024 Changes on MOV, RW, typeData, addr and wdata during ACCESS, DONE or FAULT SHALL be ignored.
REQ-025 A MOV that remains 1 across the DONE-to-IDLE boundary SHALL NOT start a new operation; the block SHALL require MOV=0 to be sampled first.
REQ-026 The wait counter SHALL be 4 bits and SHALL NOT wrap; it SHALL reload on every ACCESS entry.

Reset
REQ-027 When CLR=0, the block SHALL immediately force IDLE and set MOC, fault, mem_en, mem_we, mem_be, mem_addr, mem_wdata and rdata to 0.
REQ-028 A reset asserted during ACCESS SHALL abort the access with mem_en low asynchronously, and no MOC SHALL follow.
REQ-029 After CLR deasserts, the first operation SHALL be accepted no earlier than the first rising edge with MOV=1.

Structure
REQ-030 A shared package ram_ctrl_pkg SHALL hold the typeData encodings (BYTE, HALF, WORD, RSVD), the state enumeration, and the RW read/write constants.
REQ-031 Lane steering and fault detection SHALL be a combinational sub-module ram_lane_align, instantiated once for both the write and read paths.
REQ-032 All outputs SHALL be registered or decoded directly from state, with no combinational path from MOV to MOC.

Verification
REQ-033 Word write: WAIT_STATES=2, MOV=1, RW=0, typeData=10, addr=0x004, wdata=0xDEADBEEF -> mem_en high 3 cycles, be=1111, mem_addr=1, and MOC high after edge 4.
REQ-034 Byte read: memory word at 0x008 = 0x11223344, typeData=00, addr=0x00A -> be=0100 and rdata=0x00000022.
REQ-035 Misaligned halfword: typeData=01, addr=0x003 -> FAULT, mem_en never high, MOC=fault=1 until MOV=0, then both are 0 one edge later.
REQ-036 Held MOV: MOV is kept at 1 for 10 cycles after MOC -> exactly one RAM access occurs and the block stays in DONE.
REQ-037 Reset mid-access: CLR=0 in the second ACCESS cycle -> mem_en=0 immediately, and MOC stays 0 after CLR=1 while MOV=0.
REQ-038 WAIT_STATES=0, halfword write 0xABCD at addr=0x012 -> one mem_en cycle, be=1100, mem_wdata=0xABCDABCD, and MOC after edge 2.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared encodings for the RAM access controller:
// access size, controller state and read/write sense.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        RSVD = 2'b11
    } data_type_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        FAULT
    } state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/ram_access_ctrl_lane_align.sv
// Little-endian byte-lane steering for stores and loads,
// plus alignment / access-size legality check.
module ram_lane_align
    import ram_ctrl_pkg::*;
(
    input  logic [1:0]  typ,
    input  logic [1:0]  lo,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data,
    output logic        illegal
);

    logic [31:0] shifted;

    assign shifted = raw_rdata >> {lo, 3'b000};

    always_comb begin
        be         = 4'b0000;
        lane_wdata = 32'h0;
        load_data  = 32'h0;
        illegal    = 1'b0;
        unique case (data_type_e'(typ))
            BYTE: begin
                be         = 4'b0001 << lo;
                lane_wdata = {4{wdata[7:0]}};
                load_data  = {24'h0, shifted[7:0]};
            end
            HALF: begin
                illegal    = lo[0];
                be         = lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                load_data  = {16'h0, shifted[15:0]};
            end
            WORD: begin
                illegal    = |lo;
                be         = 4'b1111;
                lane_wdata = wdata;
                load_data  = raw_rdata;
            end
            RSVD: begin
                illegal    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// Four-phase MOV/MOC bridge from the control unit to a
// synchronous RAM with byte enables and wait states.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int AW          = 9
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          MOV,
    input  logic          RW,
    input  logic [1:0]    typeData,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          MOC,
    output logic          fault,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    state_e        state_q, state_d;
    logic          rw_q, rw_d;
    logic [1:0]    typ_q, typ_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          cap_q, cap_d;

    logic          idle;
    logic [1:0]    al_typ;
    logic [1:0]    al_lo;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata;
    logic [31:0]   al_load;
    logic          al_illegal;

    // In IDLE the aligner judges the live request; otherwise the latched one.
    assign idle   = (state_q == IDLE);
    assign al_typ = idle ? typeData  : typ_q;
    assign al_lo  = idle ? addr[1:0] : addr_q[1:0];

    ram_lane_align u_align (
        .typ        (al_typ),
        .lo         (al_lo),
        .wdata      (wdata_q),
        .raw_rdata  (mem_rdata),
        .be         (al_be),
        .lane_wdata (al_wdata),
        .load_data  (al_load),
        .illegal    (al_illegal)
    );

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        typ_d   = typ_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        unique case (state_q)
            IDLE: begin
                if (MOV) begin
                    rw_d    = RW;
                    typ_d   = typeData;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = 4'(WAIT_STATES);
                    cap_d   = 1'b0;
                    state_d = al_illegal ? FAULT : ACCESS;
                end
            end
            ACCESS: begin
                // Extra trailing cycle: RAM output of last enable is valid here.
                if (cap_q) begin
                    if (rw_q == RW_READ) begin
                        rdata_d = al_load;
                    end
                    cap_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == 4'd0) begin
                    cap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE, FAULT: begin
                if (!MOV) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            typ_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            cnt_q   <= 4'd0;
            cap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            typ_q   <= typ_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

    assign mem_en    = (state_q == ACCESS) && !cap_q;
    assign mem_we    = mem_en && (rw_q == RW_WRITE);
    assign mem_addr  = addr_q[AW-1:2];
    assign mem_be    = mem_en ? al_be : 4'b0000;
    assign mem_wdata = mem_en ? al_wdata : 32'h0;
    assign MOC       = (state_q == DONE) || (state_q == FAULT);
    assign fault     = (state_q == FAULT);
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl: two instances
// (WAIT_STATES=2 with a RAM model, and WAIT_STATES=0).
module tb_ram_access_ctrl;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        MOV = 1'b0;
    logic        MOV2 = 1'b0;
    logic        RW = 1'b0;
    logic [1:0]  typeData = 2'b00;
    logic [8:0]  addr = 9'h0;
    logic [31:0] wdata = 32'h0;

    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic        MOC, fault, mem_en, mem_we;
    logic [6:0]  mem_addr;
    logic [3:0]  mem_be;

    logic [31:0] rdata1, mem_wdata1;
    logic [31:0] mem_rdata1 = 32'h0;
    logic        MOC1, fault1, mem_en1, mem_we1;
    logic [6:0]  mem_addr1;
    logic [3:0]  mem_be1;

    logic [31:0] mem [0:127];
    int          en_cnt = 0;
    int          en_cnt1 = 0;
    int          base;
    int          checks = 0;
    int          errors = 0;

    ram_access_ctrl #(.WAIT_STATES(2), .AW(9)) dut (
        .CLK(CLK), .CLR(CLR), .MOV(MOV), .RW(RW),
        .typeData(typeData), .addr(addr), .wdata(wdata),
        .rdata(rdata), .MOC(MOC), .fault(fault),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    ram_access_ctrl #(.WAIT_STATES(0), .AW(9)) dut0ws (
        .CLK(CLK), .CLR(CLR), .MOV(MOV2), .RW(RW),
        .typeData(typeData), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .MOC(MOC1), .fault(fault1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_be(mem_be1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    always #5 CLK = ~CLK;

    // Synchronous RAM: read data appears the edge after an enabled cycle.
    always @(posedge CLK) begin
        if (!CLR) begin
            mem[2] <= 32'h11223344;
        end
        if (mem_en) begin
            en_cnt <= en_cnt + 1;
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
        if (mem_en1) en_cnt1 <= en_cnt1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_moc", 32'(MOC), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_en", 32'(mem_en), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_be", 32'(mem_be), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_moc1", 32'(MOC1), 32'h0);
        CLR = 1'b1;
        tick();
        chk("idle_moc", 32'(MOC), 32'h0);

        // word write, WAIT_STATES=2
        base = en_cnt;
        MOV = 1'b1; RW = 1'b0; typeData = 2'b10; addr = 9'h004; wdata = 32'hDEADBEEF;
        tick();
        chk("ww_en", 32'(mem_en), 32'h1);
        chk("ww_we", 32'(mem_we), 32'h1);
        chk("ww_be", 32'(mem_be), 32'hF);
        chk("ww_addr", 32'(mem_addr), 32'h1);
        chk("ww_wdata", mem_wdata, 32'hDEADBEEF);
        chk("ww_moc0", 32'(MOC), 32'h0);
        addr = 9'h1FF; wdata = 32'h0; typeData = 2'b11; RW = 1'b1;
        tick();
        tick();
        chk("ww_en_e2", 32'(mem_en), 32'h1);
        chk("ww_addr_e2", 32'(mem_addr), 32'h1);
        tick();
        chk("ww_en_e3", 32'(mem_en), 32'h0);
        chk("ww_moc_e3", 32'(MOC), 32'h0);
        tick();
        chk("ww_moc_e4", 32'(MOC), 32'h1);
        chk("ww_fault", 32'(fault), 32'h0);
        chk("ww_en_cycles", 32'(en_cnt - base), 32'd3);
        chk("ww_mem", mem[1], 32'hDEADBEEF);
        MOV = 1'b0;
        tick();
        chk("ww_moc_drop", 32'(MOC), 32'h0);

        // byte read at 0x00A
        MOV = 1'b1; RW = 1'b1; typeData = 2'b00; addr = 9'h00A;
        tick();
        chk("br_be", 32'(mem_be), 32'h4);
        chk("br_we", 32'(mem_we), 32'h0);
        chk("br_addr", 32'(mem_addr), 32'h2);
        tick();
        tick();
        tick();
        tick();
        chk("br_moc", 32'(MOC), 32'h1);
        chk("br_rdata", rdata, 32'h00000022);
        MOV = 1'b0;
        tick();
        chk("br_moc_drop", 32'(MOC), 32'h0);
        chk("br_hold", rdata, 32'h00000022);

        // halfword read at 0x00A
        MOV = 1'b1; RW = 1'b1; typeData = 2'b01; addr = 9'h00A;
        tick();
        chk("hr_be", 32'(mem_be), 32'hC);
        tick();
        tick();
        tick();
        tick();
        chk("hr_rdata", rdata, 32'h00001122);
        MOV = 1'b0;
        tick();

        // misaligned halfword -> FAULT
        base = en_cnt;
        MOV = 1'b1; RW = 1'b0; typeData = 2'b01; addr = 9'h003;
        tick();
        chk("mh_moc", 32'(MOC), 32'h1);
        chk("mh_fault", 32'(fault), 32'h1);
        chk("mh_en", 32'(mem_en), 32'h0);
        tick();
        tick();
        chk("mh_moc_hold", 32'(MOC), 32'h1);
        chk("mh_fault_hold", 32'(fault), 32'h1);
        chk("mh_no_access", 32'(en_cnt - base), 32'd0);
        MOV = 1'b0;
        tick();
        chk("mh_moc_drop", 32'(MOC), 32'h0);
        chk("mh_fault_drop", 32'(fault), 32'h0);

        // reserved type and misaligned word
        MOV = 1'b1; typeData = 2'b11; addr = 9'h000;
        tick();
        chk("rsvd_fault", 32'(fault), 32'h1);
        MOV = 1'b0;
        tick();
        MOV = 1'b1; typeData = 2'b10; addr = 9'h002;
        tick();
        chk("mw_fault", 32'(fault), 32'h1);
        chk("mw_en", 32'(mem_en), 32'h0);
        MOV = 1'b0;
        tick();
        chk("mw_fault_drop", 32'(fault), 32'h0);

        // held MOV: one access only, stays in DONE
        base = en_cnt;
        MOV = 1'b1; RW = 1'b1; typeData = 2'b10; addr = 9'h004;
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("hm_moc", 32'(MOC), 32'h1);
        chk("hm_rdata", rdata, 32'hDEADBEEF);
        repeat (10) tick();
        chk("hm_moc_held", 32'(MOC), 32'h1);
        chk("hm_one_access", 32'(en_cnt - base), 32'd3);
        MOV = 1'b0;
        tick();
        chk("hm_moc_drop", 32'(MOC), 32'h0);

        // WAIT_STATES=0 halfword write at 0x012
        base = en_cnt1;
        MOV2 = 1'b1; RW = 1'b0; typeData = 2'b01; addr = 9'h012; wdata = 32'h0000ABCD;
        tick();
        chk("z_en", 32'(mem_en1), 32'h1);
        chk("z_we", 32'(mem_we1), 32'h1);
        chk("z_be", 32'(mem_be1), 32'hC);
        chk("z_wdata", mem_wdata1, 32'hABCDABCD);
        chk("z_addr", 32'(mem_addr1), 32'h4);
        chk("z_moc0", 32'(MOC1), 32'h0);
        chk("z_other_idle", 32'(mem_en), 32'h0);
        tick();
        chk("z_en_e1", 32'(mem_en1), 32'h0);
        chk("z_moc_e1", 32'(MOC1), 32'h0);
        tick();
        chk("z_moc_e2", 32'(MOC1), 32'h1);
        chk("z_one_cycle", 32'(en_cnt1 - base), 32'd1);
        MOV2 = 1'b0;
        tick();
        chk("z_moc_drop", 32'(MOC1), 32'h0);

        // reset in second ACCESS cycle
        MOV = 1'b1; RW = 1'b0; typeData = 2'b10; addr = 9'h010; wdata = 32'h12345678;
        tick();
        tick();
        chk("ra_en_pre", 32'(mem_en), 32'h1);
        chk("ra_rdata_pre", rdata, 32'hDEADBEEF);
        #2 CLR = 1'b0;
        #1;
        chk("ra_en_async", 32'(mem_en), 32'h0);
        chk("ra_be_async", 32'(mem_be), 32'h0);
        chk("ra_moc_async", 32'(MOC), 32'h0);
        chk("ra_rdata_clr", rdata, 32'h0);
        MOV = 1'b0;
        tick();
        CLR = 1'b1;
        repeat (6) tick();
        chk("ra_no_moc", 32'(MOC), 32'h0);
        chk("ra_no_en", 32'(mem_en), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
